// File: rtl/countdown_seg_pkg.sv
// Shared definitions for the seconds countdown timer: FSM state encoding and
// BCD digit constants.
package countdown_defs;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Clamp a BCD preset digit to an upper limit.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_seg_digit.sv
// One BCD digit register that counts down, borrowing when decremented at 0.
module bcd_down_digit
  import countdown_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero,
  output logic             borrow
);

  // Load has priority over decrement; decrementing 0 reloads 9.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign is_zero = (digit == '0);
  assign borrow  = dec & (digit == '0) & ~load;

endmodule

// File: rtl/countdown_seg.sv
// Two-digit BCD seconds countdown timer driven by a 1 Hz tick, with
// load/start/pause control and an expiry level plus one-cycle done pulse.
module countdown_seg
  import countdown_defs::*;
#(
  parameter int unsigned MAX_TENS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_units,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             done
);

  localparam logic [BCD_W-1:0] MAX_TENS_C =
    (MAX_TENS > 9) ? BCD_MAX : BCD_W'(MAX_TENS);

  state_t           state, state_nxt;
  logic             done_nxt;
  logic [BCD_W-1:0] tens_ld, units_ld;
  logic             tens_zero, units_zero;
  logic             units_borrow, tens_borrow;
  logic             count_zero;
  logic             tick_act;
  logic             last_tick;

  assign tens_ld    = clamp_digit(load_tens, MAX_TENS_C);
  assign units_ld   = clamp_digit(load_units, BCD_MAX);
  assign count_zero = tens_zero & units_zero;

  // A tick only counts when no higher-priority request is present this cycle;
  // the count_zero guard keeps the value from ever wrapping below 00.
  assign tick_act  = tick & ~load & ~start & ~pause & (state == ST_RUN) & ~count_zero;
  assign last_tick = tick_act & tens_zero & (units == 4'd1);

  bcd_down_digit u_units (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (units_ld),
    .dec      (tick_act),
    .digit    (units),
    .is_zero  (units_zero),
    .borrow   (units_borrow)
  );

  bcd_down_digit u_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (tens_ld),
    .dec      (units_borrow),
    .digit    (tens),
    .is_zero  (tens_zero),
    .borrow   (tens_borrow)
  );

  // Next-state selection in request priority order: load > start > pause > tick.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (load) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      if (state == ST_IDLE) begin
        if (count_zero) begin
          state_nxt = ST_EXPIRED;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end else if (state == ST_PAUSE) begin
        state_nxt = ST_RUN;
      end
    end else if (pause) begin
      if (state == ST_RUN) state_nxt = ST_PAUSE;
    end else if (last_tick) begin
      state_nxt = ST_EXPIRED;
      done_nxt  = 1'b1;
    end
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      paused  <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      paused  <= (state_nxt == ST_PAUSE);
      expired <= (state_nxt == ST_EXPIRED);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_seg.sv
// Self-checking bench for countdown_seg: directed scenarios plus randomized
// control traffic, compared every cycle against an integer-count model.
module tb_countdown_seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, load, start, pause;
  logic [3:0] load_tens, load_units;
  logic [3:0] tens, units;
  logic       running, paused, expired, done;

  int checks = 0;
  int errors = 0;

  // Reference model: plain seconds count and a coarse mode number.
  // mode: 0 idle, 1 run, 2 pause, 3 expired
  int m_cnt  = 0;
  int m_mode = 0;
  int m_done = 0;

  countdown_seg #(.MAX_TENS(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .units      (units),
    .running    (running),
    .paused     (paused),
    .expired    (expired),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit r, input bit l, input int lt, input int lu,
                            input bit s, input bit p, input bit t);
    m_done = 0;
    if (r) begin
      m_cnt  = 0;
      m_mode = 0;
    end else if (l) begin
      m_cnt  = min_i(lt, 9) * 10 + min_i(lu, 9);
      m_mode = 0;
    end else if (s) begin
      if (m_mode == 0) begin
        if (m_cnt == 0) begin
          m_mode = 3;
          m_done = 1;
        end else begin
          m_mode = 1;
        end
      end else if (m_mode == 2) begin
        m_mode = 1;
      end
    end else if (p) begin
      if (m_mode == 1) m_mode = 2;
    end else if (t && m_mode == 1 && m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_mode = 3;
        m_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("tens",    int'(tens),    m_cnt / 10);
    check("units",   int'(units),   m_cnt % 10);
    check("running", int'(running), (m_mode == 1) ? 1 : 0);
    check("paused",  int'(paused),  (m_mode == 2) ? 1 : 0);
    check("expired", int'(expired), (m_mode == 3) ? 1 : 0);
    check("done",    int'(done),    m_done);
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample #1 later.
  task automatic step(input bit r, input bit l, input int lt, input int lu,
                      input bit s, input bit p, input bit t);
    rst_n      = ~r;
    load       = l;
    load_tens  = 4'(lt);
    load_units = 4'(lu);
    start      = s;
    pause      = p;
    tick       = t;
    @(posedge clk);
    model_step(r, l, lt, lu, s, p, t);
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();   step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_tick();    step(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_start();   step(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_pause();   step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_load(input int lt, input int lu); step(0, 1, lt, lu, 0, 0, 0); endtask

  initial begin
    rst_n = 1'b0; tick = 0; load = 0; start = 0; pause = 0;
    load_tens = '0; load_units = '0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_tens", int'(tens), 0);
    check("rst_flags", int'({running, paused, expired, done}), 0);

    // Reset mid-RUN at 37
    do_load(3, 7); do_start(); idle_cyc();
    check("run37", int'(running), 1);
    step(1, 0, 0, 0, 0, 0, 1);
    check("rst37_cnt", int'({tens, units}), 0);
    check("rst37_flags", int'({running, paused, expired, done}), 0);

    // 05 down to 00, done one cycle after the fifth tick
    do_load(0, 5); do_start();
    for (int i = 4; i >= 0; i--) begin
      do_tick();
      check("cd05_units", int'(units), i);
    end
    check("cd05_done", int'(done), 1);
    check("cd05_exp", int'(expired), 1);
    do_tick();
    check("cd05_done_once", int'(done), 0);
    check("cd05_hold", int'({tens, units}), 0);
    do_tick(); do_tick();
    check("cd05_exp_hold", int'(expired), 1);

    // Borrow path 20 -> 19 -> 18
    do_load(2, 0); do_start(); do_tick();
    check("brw19", int'({tens, units}), 8'h19);
    do_tick();
    check("brw18", int'({tens, units}), 8'h18);

    // Pause window
    do_load(1, 2); do_start(); do_tick(); do_tick(); do_pause();
    check("pause_flag", int'(paused), 1);
    do_tick(); do_tick(); do_tick();
    check("pause_hold", int'({tens, units}), 8'h10);
    do_start();
    check("resume_flag", int'(paused), 0);
    do_tick();
    check("resume09", int'({tens, units}), 8'h09);

    // Start at 00 expires immediately; load clamps and ignores tick
    do_load(0, 0); do_start();
    check("zero_done", int'(done), 1);
    check("zero_exp", int'(expired), 1);
    step(0, 1, 15, 15, 0, 0, 1);
    check("clamp99", int'({tens, units}), 8'h99);
    check("clamp_idle", int'({running, expired}), 0);

    // start+tick together from IDLE at 03
    do_load(0, 3);
    step(0, 0, 0, 0, 1, 0, 1);
    check("st_tick03", int'({tens, units}), 8'h03);
    do_tick();
    check("st_tick02", int'({tens, units}), 8'h02);
    do_start();
    check("restart_nop", int'({tens, units, running}), {8'h02, 1'b1});

    // Back-to-back ticks from 99 down through expiry
    do_load(9, 9); do_start();
    for (int i = 0; i < 100; i++) do_tick();
    check("b2b_exp", int'(expired), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, l, s, p, t;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 14) == 0);
      t = ($urandom_range(0, 1) == 0);
      step(r, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), s, p, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
